// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr N:1 stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic OUT_VALID_RST = 1'b0;
    localparam logic ERR_SEL_RST   = 1'b0;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Pointer starts on the last channel so the first round-robin grant lands on channel 0.
    function automatic int unsigned rr_ptr_rst(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward with wrap; owns the rotating pointer.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N  = 31,
    parameter int unsigned SW = clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          adv,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [SW-1:0] ptr_q;
    int unsigned   idx;

    // ptr is the index to remember when a grant is consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= SW'(rr_ptr_rst(N));
        end else if (adv) begin
            ptr_q <= ptr;
        end
    end

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_vld && req[SW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream multiplexer with fixed or round-robin selection and a registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned N  = 31,
    parameter int unsigned W  = 2,
    parameter int unsigned SW = clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err_sel
);

    localparam int unsigned NP  = 32'd1 << SW;
    localparam int unsigned SWP = SW + 1;

    logic [W-1:0]  ch_data [N];
    logic [NP-1:0] vld_pad;
    logic          sel_ok;
    logic          fixed_vld;
    logic [SW-1:0] rr_idx;
    logic          rr_vld;
    logic [SW-1:0] gnt_idx;
    logic          gnt_vld;
    logic [W-1:0]  gnt_data;
    logic          load_en;
    logic          xfer;
    logic          is_rr;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*W +: W];
    end

    // Pad valids to the full select range so out-of-range sel reads a zero
    assign vld_pad   = NP'(in_valid);
    assign sel_ok    = ({1'b0, sel} < SWP'(N));
    assign fixed_vld = sel_ok && vld_pad[sel];
    assign is_rr     = (mode == MODE_RR);

    assign load_en = !out_valid || out_ready;
    assign gnt_idx = is_rr ? rr_idx : sel;
    assign gnt_vld = is_rr ? rr_vld : fixed_vld;
    assign xfer    = gnt_vld && load_en;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (in_valid),
        .ptr     (rr_idx),
        .adv     (xfer && is_rr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_data    = ch_data[i];
                in_ready[i] = xfer;
            end
        end
    end

    // Single-register output stage; a drain and a load in the same cycle keeps out_valid high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= OUT_VALID_RST;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_chan  <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sel <= ERR_SEL_RST;
        end else if (!is_rr && !sel_ok && (|in_valid)) begin
            err_sel <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed fixed/round-robin, backpressure and reset cases.
module tb_stream_mux_rr;

    localparam int unsigned N  = 31;
    localparam int unsigned W  = 2;
    localparam int unsigned SW = 5;

    typedef struct packed {
        logic [SW-1:0] chan;
        logic [W-1:0]  data;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;
    logic           err_sel;

    logic [W-1:0] chdat [N];
    exp_t         q [$];
    int           checks = 0;
    int           errors = 0;

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel)
    );

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign in_data[i*W +: W] = chdat[i];
    end

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int d);
        q.push_back({SW'(c), W'(d)});
    endtask

    task automatic send_fixed(input int s, input int d);
        sel      = SW'(s);
        in_valid = 31'(1) << s;
        #1;
        chk("fixed_in_ready", int'(in_ready), int'(31'(1) << s));
        push(s, d);
        step();
        in_valid = '0;
        chk("fixed_out_valid", int'(out_valid), 1);
        step();
        chk("fixed_drain", int'(out_valid), 0);
    endtask

    // Monitor: every accepted output word must match the next scoreboard entry
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word chan=%0d data=%0d required=none", out_chan, out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_chan != e.chan || out_data != e.data) begin
                    errors++;
                    $display("FAIL out_word actual chan=%0d data=%0d required chan=%0d data=%0d",
                             out_chan, out_data, e.chan, e.data);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(N); i++) chdat[i] = '0;
        chdat[0]  = 2'b01;
        chdat[5]  = 2'b10;
        chdat[12] = 2'b10;
        chdat[30] = 2'b11;
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_chan", int'(out_chan), 0);
        chk("rst_err_sel", int'(err_sel), 0);
        reset = 1'b0;
        step();

        // T1 / T2: fixed select
        send_fixed(12, 2);
        send_fixed(30, 3);

        // T3: out-of-range select sets the sticky flag and grants nothing
        sel      = SW'(31);
        in_valid = '1;
        #1;
        chk("oor_in_ready", int'(in_ready), 0);
        step();
        chk("oor_out_valid", int'(out_valid), 0);
        chk("oor_err_sel", int'(err_sel), 1);
        in_valid = '0;
        sel      = '0;
        step();
        chk("err_sel_sticky", int'(err_sel), 1);

        // T4: round-robin from reset over channels 0,5,30 continuing into T5
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rr_rst_err_sel", int'(err_sel), 0);
        mode     = 1'b1;
        in_valid = '0;
        in_valid[0]  = 1'b1;
        in_valid[5]  = 1'b1;
        in_valid[30] = 1'b1;
        push(0, 1); push(5, 2); push(30, 3);
        push(0, 1); push(5, 2); push(30, 3);
        repeat (6) step();

        // T5: stall with the word from channel 30 held
        out_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_chan", int'(out_chan), 30);
            chk("stall_data", int'(out_data), 3);
            chk("stall_in_ready", int'(in_ready), 0);
            step();
        end
        push(0, 1);
        push(5, 2);
        out_ready = 1'b1;
        step();
        step();
        in_valid = '0;
        step();
        chk("rr_idle", int'(out_valid), 0);

        // T6: asynchronous reset while a word is pending
        in_valid     = '0;
        in_valid[30] = 1'b1;
        out_ready    = 1'b0;
        step();
        in_valid = '0;
        chk("pend_valid", int'(out_valid), 1);
        chk("pend_chan", int'(out_chan), 30);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_chan", int'(out_chan), 0);
        step();
        reset = 1'b0;
        out_ready    = 1'b1;
        in_valid[5]  = 1'b1;
        in_valid[30] = 1'b1;
        push(5, 2);
        #1;
        chk("post_rst_in_ready", int'(in_ready), int'(31'(1) << 5));
        step();
        in_valid = '0;
        step();
        chk("post_rst_idle", int'(out_valid), 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("scoreboard_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
